// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundle for regfile_write_arbiter: primary/secondary write requests,
// register-file write port, hazard lookup and stats.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ext_valid;
    logic              ext_ready;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic [CNT_W-1:0]  ext_count;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic [15:0]       stall_cycles;

    modport master (
        output wb_valid, wb_addr, wb_data, ext_valid, ext_addr, ext_data, chk_addr1, chk_addr2,
        input  wb_ready, ext_ready, ext_count, rf_we, rf_waddr, rf_wdata, pend_hit1, pend_hit2,
               stall_cycles
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, ext_valid, ext_addr, ext_data, chk_addr1, chk_addr2,
        output wb_ready, ext_ready, ext_count, rf_we, rf_waddr, rf_wdata, pend_hit1, pend_hit2,
               stall_cycles
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between writeback and a buffered secondary path.
// Define REGFILE_ARB_STATS_EN to build the primary stall counter (stall_cycles).
module regfile_write_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [ADDR_W-1:0]   fifoAddr [DEPTH];
    logic [DATA_W-1:0]   fifoData [DEPTH];
    logic [PTR_W-1:0]    rdPtr;
    logic [PTR_W-1:0]    wrPtr;
    logic [CNT_W-1:0]    fifoCount;
    logic [STARVE_W-1:0] starveCnt;

    logic                empty;
    logic                full;
    logic                starve;
    logic                grantWb;
    logic                grantExt;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   grantAddr;
    logic [DATA_W-1:0]   grantData;

    logic                rfWe;
    logic [ADDR_W-1:0]   rfWaddr;
    logic [DATA_W-1:0]   rfWdata;

    logic [PTR_W-1:0]    slotOffset;
    logic                hit1;
    logic                hit2;

    always_comb begin
        empty     = (fifoCount == '0);
        full      = (fifoCount == CNT_W'(DEPTH));
        starve    = !empty && (starveCnt == STARVE_W'(STARVE_MAX));
        grantExt  = starve || (!bus.wb_valid && !empty);
        grantWb   = !starve && bus.wb_valid;
        push      = bus.ext_valid && !full;
        pop       = grantExt;
        grantAddr = grantExt ? fifoAddr[rdPtr] : bus.wb_addr;
        grantData = grantExt ? fifoData[rdPtr] : bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
            starveCnt <= '0;
            rfWe      <= 1'b0;
            rfWaddr   <= '0;
            rfWdata   <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);

            if (empty || grantExt) begin
                starveCnt <= '0;
            end else if (starveCnt != STARVE_W'(STARVE_MAX)) begin
                starveCnt <= starveCnt + STARVE_W'(1);
            end

            // r0 writes are consumed but never reach the register file.
            if (grantExt || grantWb) begin
                rfWe    <= (grantAddr != '0);
                rfWaddr <= grantAddr;
                rfWdata <= grantData;
            end else begin
                rfWe <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifoAddr[wrPtr] <= bus.ext_addr;
            fifoData[wrPtr] <= bus.ext_data;
        end
    end

    always_comb begin
        hit1       = 1'b0;
        hit2       = 1'b0;
        slotOffset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotOffset = PTR_W'(i) - rdPtr;
            if (CNT_W'(slotOffset) < fifoCount) begin
                if (fifoAddr[i] == bus.chk_addr1) hit1 = 1'b1;
                if (fifoAddr[i] == bus.chk_addr2) hit2 = 1'b1;
            end
        end
        if (rfWe && (rfWaddr == bus.chk_addr1)) hit1 = 1'b1;
        if (rfWe && (rfWaddr == bus.chk_addr2)) hit2 = 1'b1;
    end

    assign bus.pend_hit1 = (bus.chk_addr1 != '0) && hit1;
    assign bus.pend_hit2 = (bus.chk_addr2 != '0) && hit2;
    assign bus.wb_ready  = !starve;
    assign bus.ext_ready = !full;
    assign bus.ext_count = fifoCount;
    assign bus.rf_we     = rfWe;
    assign bus.rf_waddr  = rfWaddr;
    assign bus.rf_wdata  = rfWdata;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (bus.wb_valid && starve && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stallCnt;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: scenario tasks plus a commit scoreboard.
module tb_regfile_write_arbiter;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

`ifdef REGFILE_ARB_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd1;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    logic clk;
    logic rst;
    int   nVectors;
    int   nMiscompares;
    wr_t  expQ[$];
    wr_t  monExp;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) bus ();

    regfile_write_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .DEPTH     (2),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every committed write must match the oldest predicted commit.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            nVectors++;
            if (expQ.size() == 0) begin
                nMiscompares++;
                $display("FAIL sb_unexpected: got addr=%0d data=%h, required no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                monExp = expQ.pop_front();
                if (bus.rf_waddr !== monExp.a || bus.rf_wdata !== monExp.d) begin
                    nMiscompares++;
                    $display("FAIL sb_commit: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, monExp.a, monExp.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        nVectors++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
            nMiscompares++;
            $display("FAIL reset_rf: got we=%b addr=%0d data=%h, required 0/0/0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        nVectors++;
        if (bus.ext_count !== 2'd0 || bus.ext_ready !== 1'b1) begin
            nMiscompares++;
            $display("FAIL reset_fifo: got count=%0d ready=%b, required 0/1",
                     bus.ext_count, bus.ext_ready);
        end
        nVectors++;
        if (bus.wb_ready !== 1'b1 || bus.stall_cycles !== 16'd0) begin
            nMiscompares++;
            $display("FAIL reset_misc: got wb_ready=%b stall=%0d, required 1/0",
                     bus.wb_ready, bus.stall_cycles);
        end
    endtask

    task automatic test_primary();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'hDEADBEEF;
        expQ.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        #1;
        nVectors++;
        if (bus.wb_ready !== 1'b1) begin
            nMiscompares++;
            $display("FAIL primary_ready: got %b, required 1", bus.wb_ready);
        end
        step();
        bus.wb_valid = 1'b0;
        nVectors++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
            nMiscompares++;
            $display("FAIL primary_commit: got we=%b addr=%0d data=%h, required 1/5/deadbeef",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        step();
        nVectors++;
        if (bus.rf_we !== 1'b0) begin
            nMiscompares++;
            $display("FAIL primary_idle: got we=%b, required 0", bus.rf_we);
        end
    endtask

    task automatic test_r0();
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'h1234;
        bus.chk_addr1 = 5'd0;
        #1;
        nVectors++;
        if (bus.wb_ready !== 1'b1 || bus.pend_hit1 !== 1'b0) begin
            nMiscompares++;
            $display("FAIL r0_accept: got wb_ready=%b hit1=%b, required 1/0",
                     bus.wb_ready, bus.pend_hit1);
        end
        step();
        bus.wb_valid = 1'b0;
        nVectors++;
        if (bus.rf_we !== 1'b0 || bus.rf_wdata !== 32'h1234) begin
            nMiscompares++;
            $display("FAIL r0_drop: got we=%b data=%h, required 0/00001234",
                     bus.rf_we, bus.rf_wdata);
        end
    endtask

    task automatic test_starvation();
        bus.ext_valid = 1'b1;
        bus.ext_addr  = 5'd9;
        bus.ext_data  = 32'd7;
        for (int i = 0; i < 5; i++) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = 5'(17 + i);
            bus.wb_data  = 32'(100 + i);
            expQ.push_back('{a: 5'(17 + i), d: 32'(100 + i)});
            #1;
            nVectors++;
            if (bus.wb_ready !== 1'b1) begin
                nMiscompares++;
                $display("FAIL starve_win%0d: got wb_ready=%b, required 1", i, bus.wb_ready);
            end
            step();
            bus.ext_valid = 1'b0;
        end
        bus.wb_addr = 5'd22;
        bus.wb_data = 32'd200;
        expQ.push_back('{a: 5'd9, d: 32'd7});
        #1;
        nVectors++;
        if (bus.wb_ready !== 1'b0 || bus.ext_count !== 2'd1) begin
            nMiscompares++;
            $display("FAIL starve_grant: got wb_ready=%b count=%0d, required 0/1",
                     bus.wb_ready, bus.ext_count);
        end
        step();
        nVectors++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'd7) begin
            nMiscompares++;
            $display("FAIL starve_commit: got we=%b addr=%0d data=%h, required 1/9/7",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        nVectors++;
        if (bus.stall_cycles !== EXP_STALL) begin
            nMiscompares++;
            $display("FAIL starve_stats: got %0d, required %0d", bus.stall_cycles, EXP_STALL);
        end
        expQ.push_back('{a: 5'd22, d: 32'd200});
        #1;
        nVectors++;
        if (bus.wb_ready !== 1'b1) begin
            nMiscompares++;
            $display("FAIL starve_release: got wb_ready=%b, required 1", bus.wb_ready);
        end
        step();
        bus.wb_valid = 1'b0;
        step();
    endtask

    task automatic test_fifo_full_order();
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd25;
        bus.wb_data   = 32'd500;
        bus.ext_valid = 1'b1;
        bus.ext_addr  = 5'd3;
        bus.ext_data  = 32'd33;
        expQ.push_back('{a: 5'd25, d: 32'd500});
        step();
        bus.wb_addr  = 5'd26;
        bus.wb_data  = 32'd501;
        bus.ext_addr = 5'd4;
        bus.ext_data = 32'd44;
        expQ.push_back('{a: 5'd26, d: 32'd501});
        #1;
        nVectors++;
        if (bus.ext_ready !== 1'b1 || bus.ext_count !== 2'd1) begin
            nMiscompares++;
            $display("FAIL fifo_half: got ready=%b count=%0d, required 1/1",
                     bus.ext_ready, bus.ext_count);
        end
        step();
        nVectors++;
        if (bus.ext_ready !== 1'b0 || bus.ext_count !== 2'd2) begin
            nMiscompares++;
            $display("FAIL fifo_full: got ready=%b count=%0d, required 0/2",
                     bus.ext_ready, bus.ext_count);
        end
        bus.wb_valid = 1'b0;
        bus.ext_addr = 5'd8;
        bus.ext_data = 32'd88;
        expQ.push_back('{a: 5'd3, d: 32'd33});
        step();
        nVectors++;
        if (bus.ext_count !== 2'd1) begin
            nMiscompares++;
            $display("FAIL fifo_reject: got count=%0d, required 1", bus.ext_count);
        end
        expQ.push_back('{a: 5'd4, d: 32'd44});
        #1;
        nVectors++;
        if (bus.ext_ready !== 1'b1) begin
            nMiscompares++;
            $display("FAIL fifo_pushpop_ready: got %b, required 1", bus.ext_ready);
        end
        step();
        bus.ext_valid = 1'b0;
        nVectors++;
        if (bus.ext_count !== 2'd1 || bus.rf_waddr !== 5'd4) begin
            nMiscompares++;
            $display("FAIL fifo_pushpop: got count=%0d addr=%0d, required 1/4",
                     bus.ext_count, bus.rf_waddr);
        end
        expQ.push_back('{a: 5'd8, d: 32'd88});
        step();
        nVectors++;
        if (bus.ext_count !== 2'd0) begin
            nMiscompares++;
            $display("FAIL fifo_drain: got count=%0d, required 0", bus.ext_count);
        end
        step();
    endtask

    task automatic test_hazard();
        bus.chk_addr1 = 5'd13;
        bus.chk_addr2 = 5'd12;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd13;
        bus.wb_data   = 32'd1300;
        bus.ext_valid = 1'b1;
        bus.ext_addr  = 5'd12;
        bus.ext_data  = 32'd1212;
        expQ.push_back('{a: 5'd13, d: 32'd1300});
        #1;
        nVectors++;
        if (bus.pend_hit2 !== 1'b0 || bus.pend_hit1 !== 1'b0) begin
            nMiscompares++;
            $display("FAIL hazard_none: got hit1=%b hit2=%b, required 0/0",
                     bus.pend_hit1, bus.pend_hit2);
        end
        step();
        bus.wb_valid  = 1'b0;
        bus.ext_valid = 1'b0;
        expQ.push_back('{a: 5'd12, d: 32'd1212});
        #1;
        nVectors++;
        if (bus.pend_hit2 !== 1'b1 || bus.pend_hit1 !== 1'b1) begin
            nMiscompares++;
            $display("FAIL hazard_fifo: got hit1=%b hit2=%b, required 1/1",
                     bus.pend_hit1, bus.pend_hit2);
        end
        step();
        nVectors++;
        if (bus.pend_hit2 !== 1'b1 || bus.pend_hit1 !== 1'b0) begin
            nMiscompares++;
            $display("FAIL hazard_commit: got hit1=%b hit2=%b, required 0/1",
                     bus.pend_hit1, bus.pend_hit2);
        end
        step();
        nVectors++;
        if (bus.pend_hit2 !== 1'b0) begin
            nMiscompares++;
            $display("FAIL hazard_clear: got hit2=%b, required 0", bus.pend_hit2);
        end
    endtask

    task automatic test_reset_mid();
        bus.chk_addr1 = 5'd15;
        bus.chk_addr2 = 5'd16;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd14;
        bus.wb_data   = 32'd1400;
        bus.ext_valid = 1'b1;
        bus.ext_addr  = 5'd15;
        bus.ext_data  = 32'd1500;
        expQ.push_back('{a: 5'd14, d: 32'd1400});
        step();
        bus.wb_addr  = 5'd16;
        bus.wb_data  = 32'd1600;
        bus.ext_addr = 5'd18;
        bus.ext_data = 32'd1800;
        expQ.push_back('{a: 5'd16, d: 32'd1600});
        step();
        bus.wb_valid  = 1'b0;
        bus.ext_valid = 1'b0;
        rst           = 1'b1;
        #1;
        nVectors++;
        if (bus.ext_count !== 2'd2 || bus.rf_we !== 1'b1 || bus.pend_hit1 !== 1'b1) begin
            nMiscompares++;
            $display("FAIL rstmid_pre: got count=%0d we=%b hit1=%b, required 2/1/1",
                     bus.ext_count, bus.rf_we, bus.pend_hit1);
        end
        step();
        rst = 1'b0;
        #1;
        nVectors++;
        if (bus.rf_we !== 1'b0 || bus.ext_count !== 2'd0) begin
            nMiscompares++;
            $display("FAIL rstmid_state: got we=%b count=%0d, required 0/0",
                     bus.rf_we, bus.ext_count);
        end
        nVectors++;
        if (bus.pend_hit1 !== 1'b0 || bus.pend_hit2 !== 1'b0 || bus.stall_cycles !== 16'd0) begin
            nMiscompares++;
            $display("FAIL rstmid_flags: got hit1=%b hit2=%b stall=%0d, required 0/0/0",
                     bus.pend_hit1, bus.pend_hit2, bus.stall_cycles);
        end
        bus.ext_valid = 1'b1;
        bus.ext_addr  = 5'd7;
        bus.ext_data  = 32'd77;
        expQ.push_back('{a: 5'd7, d: 32'd77});
        step();
        bus.ext_valid = 1'b0;
        step();
        nVectors++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin
            nMiscompares++;
            $display("FAIL rstmid_resume: got we=%b addr=%0d, required 1/7",
                     bus.rf_we, bus.rf_waddr);
        end
        step();
        step();
        nVectors++;
        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("FAIL sb_drain: got %0d pending commits, required 0", expQ.size());
        end
    endtask

    initial begin
        nVectors      = 0;
        nMiscompares  = 0;
        rst           = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.ext_valid = 1'b0;
        bus.ext_addr  = '0;
        bus.ext_data  = '0;
        bus.chk_addr1 = '0;
        bus.chk_addr2 = '0;
        test_reset();
        test_primary();
        test_r0();
        test_starvation();
        test_fifo_full_order();
        test_hazard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
